// File: rtl/pipe_adder_pkg.sv
// Shared helpers for pipe_adder_stream: carry-slice sizing and saturation patterns.
package pipe_adder_pkg;

    localparam int SAT_MAX_W = 1024;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // 0111..1 in the low 'width' bits
    function automatic logic [SAT_MAX_W-1:0] sat_pos(input int width);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < width - 1; i++) r[i] = 1'b1;
        return r;
    endfunction

    // 1000..0 in the low 'width' bits
    function automatic logic [SAT_MAX_W-1:0] sat_neg(input int width);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        r[width-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// One C-bit segment of the pipelined carry chain.
module pipe_adder_slice #(
    parameter int C = 4
) (
    input  logic [C-1:0] a_i,
    input  logic [C-1:0] b_i,
    input  logic         c_i,
    output logic [C-1:0] s_o,
    output logic         c_o
);

    logic [C:0] acc;

    assign acc        = {1'b0, a_i} + {1'b0, b_i} + {{C{1'b0}}, c_i};
    assign {c_o, s_o} = acc;

endmodule

// File: rtl/pipe_adder_stream.sv
// Streaming WIDTH-bit add/subtract with the carry chain split over STAGES registered slices.
// Define PIPE_ADDER_SAT_EN to saturate sum on signed overflow in the final stage.
module pipe_adder_stream
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int C = slice_width(WIDTH, STAGES);
    localparam int L = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_chk
        $fatal(1, "pipe_adder_stream: need 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q, sum_d, sum_raw;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             v_last;
    logic [C-1:0]     a_last, b_last, s_last;

    // A stalled output freezes the whole pipe; bubbles are kept, never squeezed out.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c0       = cin ^ sub;

    // Combinational slice adders; stage k sees slice k of the skewed operands.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [C-1:0] a_s, b_s, s_s;
        logic         c_s, co_s;

        if (k == 0) begin : g_src_port
            assign a_s = a[C-1:0];
            assign b_s = b_eff[C-1:0];
            assign c_s = c0;
        end else begin : g_src_reg
            assign a_s = g_reg[k-1].a_hi_q[C-1:0];
            assign b_s = g_reg[k-1].b_hi_q[C-1:0];
            assign c_s = g_reg[k-1].c_q;
        end

        pipe_adder_slice #(.C(C)) u_slice (
            .a_i (a_s),
            .b_i (b_s),
            .c_i (c_s),
            .s_o (s_s),
            .c_o (co_s)
        );
    end

    // Inter-stage registers: pending upper operand bits above, resolved result bits below.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_reg
        localparam int HI_W = WIDTH - (k + 1) * C;
        localparam int LO_W = (k + 1) * C;

        logic            v_q, v_d;
        logic            c_q;
        logic [HI_W-1:0] a_hi_q, a_hi_d;
        logic [HI_W-1:0] b_hi_q, b_hi_d;
        logic [LO_W-1:0] lo_q, lo_d;

        if (k == 0) begin : g_nxt_port
            assign v_d    = in_valid;
            assign a_hi_d = a[WIDTH-1:C];
            assign b_hi_d = b_eff[WIDTH-1:C];
            assign lo_d   = g_stg[0].s_s;
        end else begin : g_nxt_reg
            assign v_d    = g_reg[k-1].v_q;
            assign a_hi_d = g_reg[k-1].a_hi_q[HI_W+C-1:C];
            assign b_hi_d = g_reg[k-1].b_hi_q[HI_W+C-1:C];
            assign lo_d   = {g_stg[k].s_s, g_reg[k-1].lo_q};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q    <= 1'b0;
                c_q    <= 1'b0;
                a_hi_q <= '0;
                b_hi_q <= '0;
                lo_q   <= '0;
            end else if (en) begin
                v_q    <= v_d;
                c_q    <= g_stg[k].co_s;
                a_hi_q <= a_hi_d;
                b_hi_q <= b_hi_d;
                lo_q   <= lo_d;
            end
        end
    end

    assign a_last = g_stg[L].a_s;
    assign b_last = g_stg[L].b_s;
    assign s_last = g_stg[L].s_s;

    if (STAGES == 1) begin : g_out_one
        assign sum_raw = s_last;
        assign v_last  = in_valid;
    end else begin : g_out_many
        assign sum_raw = {s_last, g_reg[L-1].lo_q};
        assign v_last  = g_reg[L-1].v_q;
    end

    assign carry_d = g_stg[L].co_s;
    assign ovf_d   = (a_last[C-1] == b_last[C-1]) && (s_last[C-1] != a_last[C-1]);

`ifdef PIPE_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));

    // Overflow direction follows the operand sign; flags still report the raw result.
    always_comb begin
        sum_d = sum_raw;
        if (ovf_d) sum_d = a_last[C-1] ? SAT_NEG : SAT_POS;
    end
`else
    assign sum_d = sum_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= v_last;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipe_adder_stream.sv
// Directed and random checks of pipe_adder_stream (8/2 main instance, 32-bit sweep instances).
module tb_pipe_adder_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst;
    logic       iv, ir, ov, ordy, ci, sb, cy, of;
    logic [7:0] a, b, s;

    pipe_adder_stream #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(ci), .sub(sb),
        .out_valid(ov), .out_ready(ordy), .sum(s), .carry(cy), .overflow(of)
    );

    logic        wv, wci, wsb;
    logic [31:0] wa, wb;
    logic [2:0]  wir, wov, wcy, wof;
    logic [31:0] ws [3];

    pipe_adder_stream #(.WIDTH(32), .STAGES(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(wv), .in_ready(wir[0]), .a(wa), .b(wb), .cin(wci), .sub(wsb),
        .out_valid(wov[0]), .out_ready(1'b1), .sum(ws[0]), .carry(wcy[0]), .overflow(wof[0])
    );
    pipe_adder_stream #(.WIDTH(32), .STAGES(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(wv), .in_ready(wir[1]), .a(wa), .b(wb), .cin(wci), .sub(wsb),
        .out_valid(wov[1]), .out_ready(1'b1), .sum(ws[1]), .carry(wcy[1]), .overflow(wof[1])
    );
    pipe_adder_stream #(.WIDTH(32), .STAGES(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(wv), .in_ready(wir[2]), .a(wa), .b(wb), .cin(wci), .sub(wsb),
        .out_valid(wov[2]), .out_ready(1'b1), .sum(ws[2]), .carry(wcy[2]), .overflow(wof[2])
    );

    // Reference arithmetic: returns {overflow, carry, sum} with sum in the low w bits.
    function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic sbt);
        logic [32:0] full;
        logic [31:0] mask, xx, yy, r;
        logic        co, vo;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        xx   = x & mask;
        yy   = (sbt ? ~y : y) & mask;
        full = {1'b0, xx} + {1'b0, yy} + {32'd0, c ^ sbt};
        r    = full[31:0] & mask;
        co   = full[w];
        vo   = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
`ifdef PIPE_ADDER_SAT_EN
        if (vo) r = xx[w-1] ? (32'd1 << (w - 1)) : ((32'd1 << (w - 1)) - 32'd1);
`endif
        return {vo, co, r};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ov !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov); end
        checks++; if (s !== 8'h00)  begin errors++; $display("FAIL reset_sum: got %h want 00", s); end
        checks++; if (cy !== 1'b0)  begin errors++; $display("FAIL reset_carry: got %b want 0", cy); end
        checks++; if (of !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b want 0", of); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (ir !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", ir); end
        checks++; if (ov !== 1'b0)  begin errors++; $display("FAIL reset_idle_valid: got %b want 0", ov); end
    endtask

    task automatic test_add();
        logic [7:0] va[4], vb[4], es[4];
        logic       vc[4], ec[4], eo[4];
        va = '{8'hFF, 8'h7F, 8'h12, 8'h0F};
        vb = '{8'hFF, 8'h01, 8'h34, 8'h01};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0};
        es = '{8'hFE, 8'h80, 8'h47, 8'h10};
        ec = '{1'b1, 1'b0, 1'b0, 1'b0};
        eo = '{1'b0, 1'b1, 1'b0, 1'b0};
`ifdef PIPE_ADDER_SAT_EN
        es[1] = 8'h7F;
`endif
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iv = 1'b1; a = va[i]; b = vb[i]; ci = vc[i]; sb = 1'b0;
            @(posedge clk); #1;
            iv = 1'b0; a = 8'hAA; b = 8'h55; ci = 1'b1; sb = 1'b1;
            @(negedge clk);
            checks++; if (ov !== 1'b0) begin errors++; $display("FAIL add%0d_early_valid: got %b want 0", i, ov); end
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (ov !== 1'b1) begin errors++; $display("FAIL add%0d_valid: got %b want 1", i, ov); end
            checks++; if (s !== es[i]) begin errors++; $display("FAIL add%0d_sum: got %h want %h", i, s, es[i]); end
            checks++; if (cy !== ec[i]) begin errors++; $display("FAIL add%0d_carry: got %b want %b", i, cy, ec[i]); end
            checks++; if (of !== eo[i]) begin errors++; $display("FAIL add%0d_ovf: got %b want %b", i, of, eo[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sub();
        logic [7:0] va[4], vb[4], es[4];
        logic       vc[4], ec[4], eo[4];
        va = '{8'h05, 8'h03, 8'h80, 8'h05};
        vb = '{8'h03, 8'h05, 8'h01, 8'h03};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1};
        es = '{8'h02, 8'hFE, 8'h7F, 8'h01};
        ec = '{1'b1, 1'b0, 1'b1, 1'b1};
        eo = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef PIPE_ADDER_SAT_EN
        es[2] = 8'h80;
`endif
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iv = 1'b1; a = va[i]; b = vb[i]; ci = vc[i]; sb = 1'b1;
            @(posedge clk); #1;
            iv = 1'b0; a = 8'h00; b = 8'h00; ci = 1'b0; sb = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (ov !== 1'b1) begin errors++; $display("FAIL sub%0d_valid: got %b want 1", i, ov); end
            checks++; if (s !== es[i]) begin errors++; $display("FAIL sub%0d_sum: got %h want %h", i, s, es[i]); end
            checks++; if (cy !== ec[i]) begin errors++; $display("FAIL sub%0d_carry: got %b want %b", i, cy, ec[i]); end
            checks++; if (of !== eo[i]) begin errors++; $display("FAIL sub%0d_ovf: got %b want %b", i, of, eo[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp [16];
        logic [9:0]  want;
        ordy = 1'b1;
        for (int t = 0; t < 18; t++) begin
            if (t < 16) begin
                iv = 1'b1; a = 8'(t * 17 + 3); b = 8'(t * 29 + 5); ci = t[1]; sb = t[0];
                exp[t] = model(8, {24'd0, a}, {24'd0, b}, ci, sb);
            end else begin
                iv = 1'b0;
            end
            @(negedge clk);
            checks++; if (ir !== 1'b1) begin errors++; $display("FAIL b2b_in_ready t%0d: got %b want 1", t, ir); end
            if (t >= 2) begin
                want = {exp[t-2][33:32], exp[t-2][7:0]};
                checks++; if (ov !== 1'b1) begin errors++; $display("FAIL b2b_valid t%0d: got %b want 1", t, ov); end
                checks++; if ({of, cy, s} !== want) begin
                    errors++; $display("FAIL b2b_data beat%0d: got %h want %h", t - 2, {of, cy, s}, want);
                end
            end else begin
                checks++; if (ov !== 1'b0) begin errors++; $display("FAIL b2b_lead_valid t%0d: got %b want 0", t, ov); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] q[$];
        logic [10:0] held;
        logic        stall_prev;
        int          sent, got;
        sent = 0; got = 0; stall_prev = 1'b0; held = '0;
        for (int t = 0; t < 60 && got < 10; t++) begin
            ordy = !(t >= 4 && t < 9);
            iv   = (sent < 10);
            if (iv) begin a = 8'(sent * 37 + 11); b = 8'(sent * 13 + 7); ci = sent[0]; sb = sent[1]; end
            @(negedge clk);
            if (stall_prev) begin
                checks++; if ({ov, of, cy, s} !== held) begin
                    errors++; $display("FAIL bp_hold t%0d: got %h want %h", t, {ov, of, cy, s}, held);
                end
            end
            if (ov && !ordy) begin
                checks++; if (ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready t%0d: got %b want 0", t, ir); end
                held = {ov, of, cy, s};
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (ov && ordy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_extra_beat t%0d: got %h want none", t, {of, cy, s});
                end else begin
                    if ({of, cy, s} !== {q[0][33:32], q[0][7:0]}) begin
                        errors++; $display("FAIL bp_data t%0d: got %h want %h", t, {of, cy, s}, {q[0][33:32], q[0][7:0]});
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            if (iv && ir) begin
                q.push_back(model(8, {24'd0, a}, {24'd0, b}, ci, sb));
                sent++;
            end
            @(posedge clk); #1;
        end
        iv = 1'b0; ordy = 1'b1;
        checks++; if (got !== 10) begin errors++; $display("FAIL bp_delivered: got %0d want 10", got); end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL bp_leftover: got %0d want 0", q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        ordy = 1'b1;
        iv = 1'b1; a = 8'h21; b = 8'h42; ci = 1'b0; sb = 1'b0;
        @(posedge clk); #1;
        a = 8'h10; b = 8'h01;
        @(posedge clk); #1;
        checks++; if (s !== 8'h63) begin errors++; $display("FAIL rmid_pre_sum: got %h want 63", s); end
        rst = 1'b1; iv = 1'b0;
        @(posedge clk); #1;
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", ov); end
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL rmid_sum: got %h want 00", s); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rmid_ghost: got %b want 0", ov); end
        iv = 1'b1; a = 8'h33; b = 8'h44; ci = 1'b1; sb = 1'b0;
        @(posedge clk); #1;
        iv = 1'b0;
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rmid_early: got %b want 0", ov); end
        @(posedge clk); #1;
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL rmid_post_valid: got %b want 1", ov); end
        checks++; if ({of, cy, s} !== 10'h078) begin errors++; $display("FAIL rmid_post_data: got %h want 078", {of, cy, s}); end
        @(posedge clk); #1;
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rmid_tail: got %b want 0", ov); end
    endtask

    task automatic test_sweep();
        int          lat [3];
        logic [33:0] hexp [1300];
        logic        hv   [1300];
        int          beats;
        lat = '{1, 4, 32};
        beats = 0;
        for (int t = 0; t < 1300; t++) begin
            wv  = (beats < 1000) && ($urandom_range(0, 7) != 0);
            wa  = $urandom();
            wb  = $urandom();
            wci = 1'($urandom_range(0, 1));
            wsb = 1'($urandom_range(0, 1));
            hv[t]   = wv;
            hexp[t] = model(32, wa, wb, wci, wsb);
            if (wv) beats++;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                logic ev;
                ev = (t >= lat[d]) ? hv[t - lat[d]] : 1'b0;
                checks++; if (wir[d] !== 1'b1) begin errors++; $display("FAIL sweep_s%0d_ready t%0d: got %b want 1", lat[d], t, wir[d]); end
                checks++; if (wov[d] !== ev) begin errors++; $display("FAIL sweep_s%0d_valid t%0d: got %b want %b", lat[d], t, wov[d], ev); end
                if (ev) begin
                    checks++; if ({wof[d], wcy[d], ws[d]} !== hexp[t - lat[d]]) begin
                        errors++; $display("FAIL sweep_s%0d_data t%0d: got %h want %h", lat[d], t, {wof[d], wcy[d], ws[d]}, hexp[t - lat[d]]);
                    end
                end
            end
            @(posedge clk); #1;
        end
        wv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; ci = 1'b0; sb = 1'b0;
        wv = 1'b0; wa = '0; wb = '0; wci = 1'b0; wsb = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
